// File: rtl/uc_pkg.sv
// Shared ISA constants and FSM state type for the accumulator-processor control unit.
package uc_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_STA = 2'b10;
    localparam logic [1:0] OP_JCC = 2'b11;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        LOAD,
        ALU
    } uc_state_e;

endpackage

// File: rtl/uc_ctrl.sv
// Control unit: fetch/decode FSM driving RAM access and UT strobes, with sticky halt
// on a taken self-jump.
module uc_ctrl
    import uc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              carry,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic              sel_ual,
    output logic              load_r1,
    output logic              load_accu,
    output logic              load_carry,
    output logic              init_carry,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    uc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              halted_q, halted_d;

    logic [1:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;

    assign opcode  = ir_q[DATA_W-1:DATA_W-2];
    assign ir_addr = ir_q[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else if (ce) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        halted_d   = halted_q;
        mem_addr   = pc_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        load_r1    = 1'b0;
        load_accu  = 1'b0;
        load_carry = 1'b0;
        init_carry = 1'b0;
        sel_ual    = ir_q[6];

        // Reset, stall and halt all suppress every strobe and freeze the FSM.
        if (rst_n && ce && !halted_q) begin
            case (state_q)
                FETCH: begin
                    mem_en  = 1'b1;
                    state_d = DECODE;
                end
                DECODE: begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = EXEC;
                end
                EXEC: begin
                    mem_addr = ir_addr;
                    state_d  = FETCH;
                    case (opcode)
                        OP_NOR, OP_ADD: begin
                            mem_en  = 1'b1;
                            state_d = LOAD;
                        end
                        OP_STA: begin
                            mem_en = 1'b1;
                            mem_we = 1'b1;
                        end
                        default: begin
                            if (!carry) begin
                                pc_d = ir_addr;
                                // PC already points past this JCC, so a self-jump targets PC-1.
                                if (ir_addr == pc_q - ADDR_W'(1)) begin
                                    halted_d = 1'b1;
                                end
                            end else begin
                                init_carry = 1'b1;
                            end
                        end
                    endcase
                end
                LOAD: begin
                    load_r1 = 1'b1;
                    state_d = ALU;
                end
                ALU: begin
                    load_accu  = 1'b1;
                    load_carry = (opcode == OP_ADD);
                    state_d    = FETCH;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign halted = halted_q;
    assign pc     = rst_n ? pc_q : '0;

endmodule

// File: tb/tb_uc_ctrl.sv
// Self-checking bench for uc_ctrl: RAM/UT environment, directed vectors, corner sequences
// and random programs checked against an instruction-level reference model.
module tb_uc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic [7:0] mem_rdata;
    logic [5:0] mem_addr;
    logic [5:0] pc;
    logic       mem_en, mem_we, sel_ual, load_r1, load_accu, load_carry, init_carry, halted;

    always #5 clk = ~clk;

    // Environment: synchronous RAM and UT datapath.
    logic [7:0] ram [64];
    logic [7:0] acc, r1;
    logic       ut_carry;
    logic [8:0] env_sum;
    logic [7:0] ram_init [64];
    logic [7:0] acc_init;
    logic       carry_init;
    logic       env_load = 1'b0;

    assign env_sum = {1'b0, acc} + {1'b0, r1};

    always @(posedge clk) begin
        if (env_load) begin
            ram      <= ram_init;
            acc      <= acc_init;
            ut_carry <= carry_init;
            r1       <= 8'h00;
        end else begin
            if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
            if (mem_en && mem_we) ram[mem_addr] <= acc;
            if (load_r1) r1 <= mem_rdata;
            if (load_accu) begin
                acc <= sel_ual ? env_sum[7:0] : ~(acc | r1);
                if (load_carry) ut_carry <= env_sum[8];
            end
            if (init_carry) ut_carry <= 1'b0;
        end
    end

    uc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .mem_rdata  (mem_rdata),
        .carry      (ut_carry),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .sel_ual    (sel_ual),
        .load_r1    (load_r1),
        .load_accu  (load_accu),
        .load_carry (load_carry),
        .init_carry (init_carry),
        .halted     (halted),
        .pc         (pc)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {mem_en, mem_we, load_r1, load_accu, load_carry, init_carry};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_init();
        for (int i = 0; i < 64; i++) ram_init[i] = 8'h00;
    endtask

    task automatic do_reset(input bit load);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        ce       = 1'b1;
        env_load = load;
        @(negedge clk);
        chk("reset_strobes", 32'(strobes()), 32'h0);
        chk("reset_pc", 32'(pc), 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        env_load = 1'b0;
    endtask

    // Expected per-cycle behaviour: strobe vector, address when mem_en, ALU op when load_accu.
    typedef struct packed {
        logic [5:0] s;
        logic [5:0] a;
        logic       sel;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] iss_mem [64];
    logic [7:0] iss_a;
    logic       iss_c;
    logic [5:0] iss_p;
    logic       iss_h;

    function automatic exp_t mk(input logic [5:0] s, input logic [5:0] a, input logic sel);
        exp_t e;
        e.s   = s;
        e.a   = a;
        e.sel = sel;
        return e;
    endfunction

    task automatic build_trace(input int n_instr);
        logic [7:0] m [64];
        logic [7:0] a, ir, opnd;
        logic [8:0] s;
        logic [5:0] p, here, tgt;
        logic       c, h;
        m = ram_init;
        a = acc_init;
        c = carry_init;
        p = 6'd0;
        h = 1'b0;
        exp_q.delete();
        for (int i = 0; i < n_instr && !h; i++) begin
            here = p;
            exp_q.push_back(mk(6'b100000, here, 1'b0));
            exp_q.push_back(mk(6'b000000, 6'd0, 1'b0));
            ir   = m[here];
            tgt  = ir[5:0];
            p    = here + 6'd1;
            opnd = m[tgt];
            case (ir[7:6])
                2'b00: begin
                    exp_q.push_back(mk(6'b100000, tgt, 1'b0));
                    exp_q.push_back(mk(6'b001000, 6'd0, 1'b0));
                    exp_q.push_back(mk(6'b000100, 6'd0, 1'b0));
                    a = ~(a | opnd);
                end
                2'b01: begin
                    exp_q.push_back(mk(6'b100000, tgt, 1'b0));
                    exp_q.push_back(mk(6'b001000, 6'd0, 1'b0));
                    exp_q.push_back(mk(6'b000110, 6'd0, 1'b1));
                    s = {1'b0, a} + {1'b0, opnd};
                    a = s[7:0];
                    c = s[8];
                end
                2'b10: begin
                    exp_q.push_back(mk(6'b110000, tgt, 1'b0));
                    m[tgt] = a;
                end
                default: begin
                    if (!c) begin
                        exp_q.push_back(mk(6'b000000, 6'd0, 1'b0));
                        if (tgt == here) h = 1'b1;
                        p = tgt;
                    end else begin
                        exp_q.push_back(mk(6'b000001, 6'd0, 1'b0));
                        c = 1'b0;
                    end
                end
            endcase
        end
        if (h) repeat (10) exp_q.push_back(mk(6'b000000, 6'd0, 1'b0));
        iss_mem = m;
        iss_a   = a;
        iss_c   = c;
        iss_p   = p;
        iss_h   = h;
    endtask

    typedef struct {
        logic [7:0] instr;
        logic [7:0] a0;
        logic       c0;
        logic [7:0] opnd;
        logic [7:0] exp_a;
        logic       exp_c;
        logic [7:0] exp_mem;
        int         cycles;
        logic [5:0] exp_pc;
        int         exp_lc;
        int         exp_ic;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lc_cnt, ic_cnt, r1_cnt, r1_cyc, accu_cyc, busy, guard, diff;
        exp_t e;
        logic [12:0] act;

        vecs[0] = '{8'h4A, 8'h00, 1'b0, 8'h05, 8'h05, 1'b0, 8'h05, 5, 6'd1, 1, 0};
        vecs[1] = '{8'h0A, 8'h0F, 1'b1, 8'h30, 8'hC0, 1'b1, 8'h30, 5, 6'd1, 0, 0};
        vecs[2] = '{8'h4A, 8'hFF, 1'b0, 8'h01, 8'h00, 1'b1, 8'h01, 5, 6'd1, 1, 0};
        vecs[3] = '{8'h4A, 8'h12, 1'b1, 8'h34, 8'h46, 1'b0, 8'h34, 5, 6'd1, 1, 0};
        vecs[4] = '{8'h8B, 8'h05, 1'b0, 8'h77, 8'h05, 1'b0, 8'h05, 3, 6'd1, 0, 0};
        vecs[5] = '{8'hC5, 8'h33, 1'b0, 8'h99, 8'h33, 1'b0, 8'h99, 3, 6'd5, 0, 0};
        vecs[6] = '{8'hC5, 8'h33, 1'b1, 8'h99, 8'h33, 1'b0, 8'h99, 3, 6'd1, 0, 1};
        vecs[7] = '{8'h0C, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, 5, 6'd1, 0, 0};

        for (int v = 0; v < 8; v++) begin
            clear_init();
            ram_init[0] = vecs[v].instr;
            ram_init[vecs[v].instr[5:0]] = vecs[v].opnd;
            acc_init   = vecs[v].a0;
            carry_init = vecs[v].c0;
            do_reset(1'b1);
            lc_cnt = 0;
            ic_cnt = 0;
            for (int cyc = 1; cyc <= vecs[v].cycles; cyc++) begin
                @(negedge clk);
                lc_cnt += int'(load_carry);
                ic_cnt += int'(init_carry);
                step();
            end
            @(negedge clk);
            chk($sformatf("vec%0d_next_fetch", v), 32'({mem_en, mem_addr}), 32'({1'b1, vecs[v].exp_pc}));
            chk($sformatf("vec%0d_pc", v), 32'(pc), 32'(vecs[v].exp_pc));
            chk($sformatf("vec%0d_acc", v), 32'(acc), 32'(vecs[v].exp_a));
            chk($sformatf("vec%0d_carry", v), 32'(ut_carry), 32'(vecs[v].exp_c));
            chk($sformatf("vec%0d_mem", v), 32'(ram[vecs[v].instr[5:0]]), 32'(vecs[v].exp_mem));
            chk($sformatf("vec%0d_lc_pulses", v), 32'(lc_cnt), 32'(vecs[v].exp_lc));
            chk($sformatf("vec%0d_ic_pulses", v), 32'(ic_cnt), 32'(vecs[v].exp_ic));
        end

        // ADD sets carry, then a JCC must clear it instead of jumping.
        clear_init();
        ram_init[0] = 8'h4A; ram_init[10] = 8'h01; ram_init[1] = 8'hC0;
        acc_init = 8'hFF; carry_init = 1'b0;
        do_reset(1'b1);
        repeat (7) step();
        @(negedge clk);
        chk("jcc_c1_carry_before", 32'(ut_carry), 32'h1);
        chk("jcc_c1_strobes", 32'(strobes()), 32'b000001);
        step();
        @(negedge clk);
        chk("jcc_c1_next_fetch", 32'({mem_en, mem_addr}), 32'({1'b1, 6'd2}));
        chk("jcc_c1_carry_after", 32'(ut_carry), 32'h0);

        // Chain of jumps ending in a self-jump at address 3.
        clear_init();
        ram_init[0] = 8'hC1; ram_init[1] = 8'hC2; ram_init[2] = 8'hC3; ram_init[3] = 8'hC3;
        acc_init = 8'h5A; carry_init = 1'b0;
        do_reset(1'b1);
        repeat (12) step();
        @(negedge clk);
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_pc", 32'(pc), 32'd3);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (strobes() != 6'b0) busy++;
            step();
        end
        chk("halt_quiet_cycles", 32'(busy), 32'h0);
        do_reset(1'b0);
        @(negedge clk);
        chk("halt_cleared", 32'(halted), 32'h0);
        chk("halt_refetch", 32'({mem_en, mem_addr}), 32'({1'b1, 6'd0}));

        // Clock-enable stall for three cycles while in LOAD.
        clear_init();
        ram_init[0] = 8'h4A; ram_init[10] = 8'h05;
        acc_init = 8'h10; carry_init = 1'b0;
        do_reset(1'b1);
        r1_cnt = 0; r1_cyc = 0; accu_cyc = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            ce = !(cyc >= 4 && cyc <= 6);
            @(negedge clk);
            if (load_r1) begin
                r1_cnt++;
                r1_cyc = cyc;
            end
            if (load_accu) accu_cyc = cyc;
            step();
        end
        ce = 1'b1;
        @(negedge clk);
        chk("stall_r1_count", 32'(r1_cnt), 32'd1);
        chk("stall_r1_cycle", 32'(r1_cyc), 32'd7);
        chk("stall_alu_cycle", 32'(accu_cyc), 32'd8);
        chk("stall_acc", 32'(acc), 32'h15);
        chk("stall_next_fetch", 32'({mem_en, mem_addr}), 32'({1'b1, 6'd1}));

        // NOR at address 63 wraps the PC to 0.
        clear_init();
        ram_init[0] = 8'hFF; ram_init[63] = 8'h0A; ram_init[10] = 8'h0F;
        acc_init = 8'hF0; carry_init = 1'b0;
        do_reset(1'b1);
        repeat (3) step();
        @(negedge clk);
        chk("wrap_fetch63", 32'({mem_en, mem_addr}), 32'({1'b1, 6'd63}));
        repeat (5) step();
        @(negedge clk);
        chk("wrap_fetch0", 32'({mem_en, mem_addr}), 32'({1'b1, 6'd0}));
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_acc", 32'(acc), 32'h00);

        // Reset landing on the ALU cycle aborts the ADD.
        clear_init();
        ram_init[0] = 8'h4A; ram_init[10] = 8'h20;
        acc_init = 8'h10; carry_init = 1'b0;
        do_reset(1'b1);
        repeat (4) step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midalu_strobes", 32'(strobes()), 32'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midalu_acc", 32'(acc), 32'h10);
        chk("midalu_refetch", 32'({mem_en, mem_addr, pc}), 32'({1'b1, 6'd0, 6'd0}));

        // Random programs with random clock-enable gaps against the reference model.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 64; i++) ram_init[i] = 8'($urandom);
            acc_init   = 8'($urandom);
            carry_init = 1'($urandom);
            build_trace(30);
            do_reset(1'b1);
            guard = 0;
            while (exp_q.size() > 0 && guard < 4000) begin
                ce = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                act = {strobes(), mem_en ? mem_addr : 6'd0, load_accu ? sel_ual : 1'b0};
                if (!ce) begin
                    chk($sformatf("rnd%0d_stall", t), 32'(act), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("rnd%0d_cycle", t), 32'(act), 32'(e));
                end
                guard++;
                step();
            end
            ce = 1'b1;
            chk($sformatf("rnd%0d_budget", t), 32'(exp_q.size()), 32'h0);
            diff = 0;
            for (int i = 0; i < 64; i++) if (ram[i] !== iss_mem[i]) diff++;
            chk($sformatf("rnd%0d_ram", t), 32'(diff), 32'h0);
            chk($sformatf("rnd%0d_acc", t), 32'(acc), 32'(iss_a));
            chk($sformatf("rnd%0d_carry", t), 32'(ut_carry), 32'(iss_c));
            chk($sformatf("rnd%0d_pc", t), 32'(pc), 32'(iss_p));
            chk($sformatf("rnd%0d_halted", t), 32'(halted), 32'(iss_h));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
